// File: rtl/briskv_pkg.sv
// Shared SoC definitions: UART line defaults and the transmitter FSM encoding.
package briskv_pkg;

    localparam int unsigned UART_CLK_HZ_DEFAULT = 27_000_000;
    localparam int unsigned UART_BAUD_DEFAULT   = 115_200;
    localparam int unsigned UART_DATA_BITS      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered full/empty flags; shared by the UART directions.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    // Requests against a full/empty buffer are dropped here, not by the caller.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_MAX);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding a baud-rate serializer, LSB first.
module uart_tx
    import briskv_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = UART_CLK_HZ_DEFAULT,
    parameter int unsigned BAUD        = UART_BAUD_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       TXD
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_baud_check
        $error("uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
    end

    uart_tx_state_t    state;
    uart_tx_state_t    state_next;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_cnt_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_next;
    logic              txd_next;
    logic              bit_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [7:0]        fifo_rdata;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;
    assign bit_done = (baud_cnt == '0);

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            TXD      <= 1'b1;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            TXD      <= txd_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && (bit_idx == LAST_BIT)) state_next = STOP;
            STOP:    if (bit_done) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values; a byte is popped straight out of IDLE or the end of STOP.
    always_comb begin
        fifo_pop      = 1'b0;
        shift_next    = shift;
        bit_idx_next  = bit_idx;
        txd_next      = TXD;
        baud_cnt_next = bit_done ? BAUD_RELOAD : (baud_cnt - BAUD_W'(1));
        case (state)
            IDLE: begin
                txd_next      = 1'b1;
                baud_cnt_next = '0;
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_next    = fifo_rdata;
                    baud_cnt_next = BAUD_RELOAD;
                    txd_next      = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    txd_next     = shift[0];
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_BIT) begin
                        txd_next = 1'b1;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        txd_next     = shift[1];
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_rdata;
                        txd_next   = 1'b0;
                    end else begin
                        txd_next      = 1'b1;
                        baud_cnt_next = '0;
                    end
                end
            end
            default: begin
                txd_next      = 1'b1;
                baud_cnt_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: frame-timeline reference model plus a line receiver decoding TXD.
module tb_uart_tx;

    localparam int CLK_HZ    = 8;
    localparam int BAUD_RATE = 1;
    localparam int DEPTH     = 4;
    localparam int CPB       = CLK_HZ / BAUD_RATE;
    localparam int FRAME     = 10 * CPB;

    logic       CLK      = 1'b0;
    logic       RESET    = 1'b1;
    logic [7:0] tx_data  = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       TXD;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: buffered bytes plus remaining cycles of the frame on the line.
    logic [7:0] m_q[$];
    int         m_rem  = 0;
    logic [7:0] m_byte = '0;
    bit         m_acc  = 1'b0;
    logic [7:0] sent_q[$];
    logic [7:0] rx_q[$];
    int         rx_phase = -1;
    logic [7:0] rx_sh    = '0;

    uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_RATE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .TXD      (TXD)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        int b;
        if (m_rem == 0) return 1'b1;
        b = (FRAME - m_rem) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[3'(b - 1)];
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_q.delete();
            m_rem  = 0;
            m_byte = '0;
            m_acc  = 1'b0;
        end else begin
            bit ready;
            bit pop;
            ready = (m_q.size() < DEPTH);
            m_acc = tx_valid && ready;
            pop   = (m_rem <= 1) && (m_q.size() > 0);
            if (m_rem > 0) m_rem--;
            if (pop) begin
                m_byte = m_q.pop_front();
                m_rem  = FRAME;
            end
            if (m_acc) begin
                m_q.push_back(tx_data);
                sent_q.push_back(tx_data);
            end
        end
    end

    // Cycle-accurate comparison of every output against the model.
    always @(negedge CLK) begin
        check_eq("txd", 32'(TXD), 32'(exp_txd()));
        check_eq("busy", 32'(busy), 32'((m_rem != 0) || (m_q.size() != 0)));
        check_eq("tx_ready", 32'(tx_ready), 32'(m_q.size() < DEPTH));
    end

    // Line receiver: finds the start edge, samples each bit in its middle.
    always @(negedge CLK) begin
        if (!RESET) begin
            rx_phase = -1;
        end else if (rx_phase < 0) begin
            if (TXD == 1'b0) rx_phase = 0;
        end else begin
            rx_phase++;
            if (rx_phase == CPB / 2) check_eq("rx_start_bit", 32'(TXD), 32'd0);
            if (rx_phase >= CPB + CPB / 2 && rx_phase < 9 * CPB && ((rx_phase - CPB / 2) % CPB) == 0)
                rx_sh[3'((rx_phase - CPB - CPB / 2) / CPB)] = TXD;
            if (rx_phase == 9 * CPB + CPB / 2) begin
                check_eq("rx_stop_bit", 32'(TXD), 32'd1);
                rx_q.push_back(rx_sh);
                rx_phase = -1;
            end
        end
    end

    initial begin
        #(30_000 * 10);
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    task automatic push_byte(input logic [7:0] b, output int waited);
        tx_data  = b;
        tx_valid = 1'b1;
        waited   = 0;
        do begin
            @(posedge CLK);
            #1;
            waited++;
        end while (!m_acc && waited < 3000);
        check_eq("push_accepted", 32'(m_acc), 32'd1);
        tx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tx_data = 8'($urandom);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_rem != 0 || m_q.size() != 0) && n < 5000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check_eq("drain", 32'(m_rem == 0 && m_q.size() == 0), 32'd1);
        idle_cycles(3);
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_count"}, 32'(rx_q.size()), 32'(sent_q.size()));
        while (rx_q.size() > 0 && sent_q.size() > 0)
            check_eq(tag, 32'(rx_q.pop_front()), 32'(sent_q.pop_front()));
        rx_q.delete();
        sent_q.delete();
    endtask

    initial begin
        int w;
        logic [9:0] line55;
        int busy_len;
        int lows;

        #1 RESET = 1'b0;
        #1;
        check_eq("reset_txd", 32'(TXD), 32'd1);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_ready", 32'(tx_ready), 32'd1);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        idle_cycles(4);

        // Single byte 0x55 with exact line timeline.
        line55 = 10'b1_0101_0101_0;
        push_byte(8'h55, w);
        check_eq("sb_busy_accept", 32'(busy), 32'd1);
        check_eq("sb_txd_accept", 32'(TXD), 32'd1);
        for (int i = 1; i <= 80; i++) begin
            @(posedge CLK);
            #1;
            check_eq("sb_line", 32'(TXD), 32'(line55[(i - 1) / CPB]));
            check_eq("sb_busy", 32'(busy), 32'd1);
        end
        @(posedge CLK);
        #1;
        check_eq("sb_busy_drop", 32'(busy), 32'd0);
        check_eq("sb_txd_idle", 32'(TXD), 32'd1);
        idle_cycles(5);
        check_eq("sb_txd_after", 32'(TXD), 32'd1);
        compare_stream("sb_rx");

        // Back-to-back bytes form one continuous 160-cycle burst.
        push_byte(8'hA3, w);
        push_byte(8'h0F, w);
        busy_len = 0;
        while (busy && busy_len < 1000) begin
            busy_len++;
            @(posedge CLK);
            #1;
        end
        check_eq("b2b_len", 32'(busy_len), 32'd160);
        wait_idle();
        check_eq("b2b_rx0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'hA3);
        check_eq("b2b_rx1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'h00), 32'h0F);
        compare_stream("b2b_rx");

        // Full FIFO with tx_valid held across the stall.
        for (int i = 1; i <= 5; i++) push_byte(8'(i), w);
        tx_valid = 1'b1;
        check_eq("full_ready_low", 32'(tx_ready), 32'd0);
        push_byte(8'h06, w);
        check_eq("full_wait", 32'(w), 32'd78);
        wait_idle();
        compare_stream("full_rx");

        // Pointer wrap with random gaps.
        for (int i = 0; i < 9; i++) begin
            idle_cycles(int'($urandom_range(0, 20)));
            push_byte(8'(8'h10 + i), w);
        end
        wait_idle();
        compare_stream("wrap_rx");

        // Reset during data bit 3 of 0xFF with two bytes buffered.
        push_byte(8'hFF, w);
        push_byte(8'h11, w);
        push_byte(8'h22, w);
        repeat (34) @(posedge CLK);
        #1 RESET = 1'b0;
        #1;
        check_eq("rst_txd", 32'(TXD), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(tx_ready), 32'd1);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        rx_q.delete();
        sent_q.delete();
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            tx_data = 8'($urandom);
            @(posedge CLK);
            #1;
            if (TXD == 1'b0) lows++;
        end
        check_eq("rst_quiet_lows", 32'(lows), 32'd0);
        check_eq("rst_quiet_rx", 32'(rx_q.size()), 32'd0);
        push_byte(8'h3C, w);
        wait_idle();
        compare_stream("rst_rx");

        // Data changes while stalled or not valid must not create bytes.
        for (int i = 0; i < 5; i++) push_byte(8'(8'h41 + i), w);
        tx_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tx_data = 8'($urandom);
            @(posedge CLK);
            #1;
        end
        tx_valid = 1'b0;
        idle_cycles(20);
        wait_idle();
        check_eq("ign_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check_eq("ign_rx", 32'(rx_q.size() > i ? rx_q[i] : 8'h00), 32'(8'h41 + i));
        rx_q.delete();
        sent_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1 UART transmitter that drives the SoC `TXD` pin, currently tied low. The core, and later a memory-mapped I/O register, writes bytes through a valid/ready handshake into a small FIFO. A baud-rate state machine then serializes each byte onto `TXD`, LSB first. It is the transmit-direction counterpart of the `RXD` input.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 27_000_000: input clock frequency.
- `BAUD`, default 115_200: line rate.
- `FIFO_DEPTH`, default 4: byte buffer entries. Must be a power of 2, at least 2.
- Derived constant `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD`, using truncating integer division. Must be at least 2; elaboration fails otherwise.

Ports:
- `CLK`, input, 1: the single clock. All state is updated on its rising edge.
- `RESET`, input, 1: asynchronous, active-low reset.
- `tx_data`, input, 8: byte to send. Sampled when the handshake fires.
- `tx_valid`, input, 1: producer has a byte.
- `tx_ready`, output, 1: FIFO can accept a byte. Equals `!fifo_full`.
- `busy`, output, 1: high when the FIFO is non-empty or the FSM is not in IDLE.
- `TXD`, output, 1: serial line. Registered, idles high.

## Operation
- Handshake: a byte is pushed when `tx_valid && tx_ready` at a rising edge. `tx_data` is ignored at any other time. When `tx_ready` is low, `tx_valid` may stay high and the producer holds its data.
- FIFO: circular buffer with read/write pointers that wrap modulo `FIFO_DEPTH`, plus an occupancy count.
  - Full: count == `FIFO_DEPTH`. No push occurs; `tx_ready` is 0.
  - Empty: count == 0. No pop occurs.
  - Simultaneous push and pop leaves the count unchanged.
- Frame: one start bit (0), then `d[0]..d[7]`, then one stop bit (1). Each bit is held for exactly `CLKS_PER_BIT` cycles, so a frame lasts `10*CLKS_PER_BIT` cycles.
- FSM states:
  - IDLE: `TXD`=1. If the FIFO is non-empty, pop into the shift register, load the baud counter, set `TXD`<=0 and go to START.
  - START: when the baud counter expires, `TXD`<=`shift[0]`, set bit index to 0, go to DATA.
  - DATA: each time the counter expires, shift right. After bit index 7 is sent, `TXD`<=1 and go to STOP.
  - STOP: when the counter expires, either pop the next byte and go straight to START with `TXD`<=0 (FIFO non-empty, no idle gap), or go to IDLE (FIFO empty).
- Baud counter: counts down from `CLKS_PER_BIT-1` to 0 and reloads on every bit transition. Its width is `$clog2(CLKS_PER_BIT)`.
- Reset, asynchronous or mid-frame: immediately `TXD`=1, `tx_ready`=1, `busy`=0, FIFO empty, state IDLE, counters 0. The partial frame is abandoned and buffered bytes are discarded.

## Timing
- Reset values: `TXD`=1, `tx_ready`=1, `busy`=0.
- Latency: when a byte is accepted at edge N into an empty, idle block:
  - `busy`=1 from edge N.
  - The pop and the falling edge of `TXD` happen at edge N+1.
  - `TXD` holds start for `CLKS_PER_BIT` cycles.
- Back-to-back bytes: the next start bit begins on the cycle right after the last stop-bit cycle, giving a continuous stream.
- `tx_ready` is computed from the registered count, so it rises the cycle after a pop from full.
- `busy` falls on the edge that ends the last stop bit while the FIFO is empty.

## Structure
- The shared package `briskv_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, STOP);
  - the UART default constants `UART_BAUD_DEFAULT` and `UART_CLK_HZ_DEFAULT`.
- Sub-module `sync_fifo`, parameterized for width and depth. It contains the pointers, count and full/empty flags, and will be reused later for the receiver.
- The top-level instantiates `uart_tx` and connects its `TXD` in place of the constant 0.

## Test plan
Benches use `CLK_FREQ_HZ`=8, `BAUD`=1 (so `CLKS_PER_BIT`=8) and `FIFO_DEPTH`=4.
- Single byte: push 0x55 into an idle block.
  - `TXD` falls 1 cycle after the accept edge.
  - Line sequence over 80 cycles: 0,1,0,1,0,1,0,1,0,1, each bit 8 cycles.
  - `busy` drops on exactly cycle 81; `TXD` stays high afterward.
- Back-to-back: push 0xA3 then 0x0F on consecutive cycles.
  - Two frames, 160 cycles total, with no idle gap; a receiver model decodes 0xA3 then 0x0F.
- Full FIFO: hold `tx_valid`=1 with bytes 0x01..0x06.
  - `tx_ready` goes low after 5 accepts (1 in the shift register, 4 buffered).
  - It rises exactly 1 cycle after each pop.
  - All 6 bytes are received in order.
- Pointer wrap: send 9 bytes, 0x10..0x18, through the depth-4 FIFO with random `tx_valid` gaps.
  - Received order and values match; no drop and no duplication.
- Reset mid-frame: assert `RESET`=0 during bit 3 of 0xFF with 2 bytes buffered.
  - `TXD`=1, `busy`=0 and `tx_ready`=1 immediately, without waiting for a clock edge.
  - After release, nothing is transmitted until a new push arrives.
- Ignored data: toggle `tx_data` while `tx_valid`=0, and while `tx_valid`=1 with `tx_ready`=0.
  - No extra bytes are transmitted.
